// File: rtl/idp_pkg.sv
// idp_pkg
//   Shared definitions for the idp datapath and its bit-serial sequencer:
//   default field widths, the idp_state encoding driven onto the datapath,
//   the sequencer FSM states and a helper that maps one onto the other.
package idp_pkg;

    // Default field widths shared by idp and idp_sequencer.
    localparam int unsigned IDP_COST_W = 8;
    localparam int unsigned IDP_ROOT_W = 16;
    localparam int unsigned IDP_DIR_W  = 4;

    // Phase code seen by the idp datapath.
    typedef enum logic [1:0] {
        STOP_ST = 2'b00,
        COST_ST = 2'b01,
        ROOT_ST = 2'b10,
        SAVE_ST = 2'b11
    } idp_state_e;

    // Sequencer control states.
    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_COST,
        SEQ_ROOT,
        SEQ_SAVE
    } seq_fsm_e;

    // Phase code that idp must see while the sequencer is in a given state.
    function automatic idp_state_e to_idp_state(input seq_fsm_e s);
        idp_state_e r;
        case (s)
            SEQ_COST: r = COST_ST;
            SEQ_ROOT: r = ROOT_ST;
            SEQ_SAVE: r = SAVE_ST;
            default:  r = STOP_ST;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/idp_piso.sv
// idp_piso
//   LSB-first load-and-shift register. With ROTATE set, the bit shifted out
//   re-enters at the MSB so the word can be replayed after W shifts.
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   load          capture din (has priority over shift)
//   shift         move one bit towards the LSB
//   din           parallel load value
//   next_lsb      LSB the register will hold after this clock edge
//                 (lets the caller register the serial bit without lag)
module idp_piso #(
    parameter int unsigned W      = 8,
    parameter bit          ROTATE = 1'b0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         next_lsb
);

    logic [W-1:0] q;
    logic [W-1:0] shifted;
    logic         fill;

    assign fill = ROTATE ? q[0] : 1'b0;

    generate
        if (W == 1) begin : g_one
            assign shifted = fill;
        end else begin : g_wide
            assign shifted = {fill, q[W-1:1]};
        end
    endgenerate

    assign next_lsb = load ? din[0] : (shift ? shifted[0] : q[0]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= shifted;
        end
    end

endmodule

// File: rtl/idp_sequencer.sv
// idp_sequencer
//   Bit-serial front/back end for the idp datapath. Accepts one parallel
//   neighbour job, streams it LSB first through a STOP->COST->ROOT->SAVE run
//   and collects idp's serial result into a parallel output word.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     job handshake; in_cost/in_root/in_dir/in_pathfunction
//   idp_state             STOP=00 COST=01 ROOT=10 SAVE=11
//   idp_pathfunction      path function latched at accept
//   idp_direction         serial direction bit
//   idp_extern_data       serial cost/root bit
//   idp_root_carry_in     high on the last COST cycle only
//   idp_result_data       serial result from idp (sampled every active cycle)
//   idp_conquest          conquest flag (sampled on the last SAVE cycle)
//   out_valid/out_ready   result handshake; out_word (bit 0 sampled first),
//                         out_conquest
//   busy                  run in progress
module idp_sequencer
    import idp_pkg::*;
#(
    parameter int unsigned COST_W  = IDP_COST_W,
    parameter int unsigned ROOT_W  = IDP_ROOT_W,
    parameter int unsigned DIR_W   = IDP_DIR_W,
    parameter int unsigned TOTAL_W = COST_W + ROOT_W + DIR_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COST_W-1:0]  in_cost,
    input  logic [ROOT_W-1:0]  in_root,
    input  logic [DIR_W-1:0]   in_dir,
    input  logic               in_pathfunction,
    output logic [1:0]         idp_state,
    output logic               idp_pathfunction,
    output logic               idp_direction,
    output logic               idp_extern_data,
    output logic               idp_root_carry_in,
    input  logic               idp_result_data,
    input  logic               idp_conquest,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TOTAL_W-1:0] out_word,
    output logic               out_conquest,
    output logic               busy
);

    localparam int unsigned CNT_W = $clog2(TOTAL_W + 1);

    // Counter holds the index of the current active cycle (1..TOTAL_W).
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] COST_END = CNT_W'(COST_W);
    localparam logic [CNT_W-1:0] ROOT_END = CNT_W'(COST_W + ROOT_W);
    localparam logic [CNT_W-1:0] DIR_END  = CNT_W'(COST_W + DIR_W);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL_W);

    seq_fsm_e           fsm_q, fsm_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [TOTAL_W-2:0] cap_q;

    logic accept, complete;
    logic cost_shift, root_shift, dir_shift;
    logic cost_next, root_next, dir_next;
    logic ext_n, dir_bit_n, carry_n;

    assign in_ready = (fsm_q == SEQ_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (fsm_q != SEQ_IDLE);

    // Each shifter advances on the edge that ends a cycle in which its bit
    // was on the wire. Direction bits go out twice (early ROOT, then SAVE);
    // the dir shifter rotates, so after DIR_W shifts it is back at dir[0]
    // and simply holds there until SAVE.
    assign cost_shift = (fsm_q == SEQ_COST);
    assign root_shift = (fsm_q == SEQ_ROOT);
    assign dir_shift  = ((fsm_q == SEQ_ROOT) && (cnt_q <= DIR_END)) ||
                        (fsm_q == SEQ_SAVE);

    idp_piso #(.W(COST_W), .ROTATE(1'b0)) u_cost (
        .clock    (clock),
        .reset    (reset),
        .load     (accept),
        .shift    (cost_shift),
        .din      (in_cost),
        .next_lsb (cost_next)
    );

    idp_piso #(.W(ROOT_W), .ROTATE(1'b0)) u_root (
        .clock    (clock),
        .reset    (reset),
        .load     (accept),
        .shift    (root_shift),
        .din      (in_root),
        .next_lsb (root_next)
    );

    idp_piso #(.W(DIR_W), .ROTATE(1'b1)) u_dir (
        .clock    (clock),
        .reset    (reset),
        .load     (accept),
        .shift    (dir_shift),
        .din      (in_dir),
        .next_lsb (dir_next)
    );

    // Next state and next serial outputs; outputs are registered so the
    // values computed here are those seen on the wires during cycle cnt_n.
    always_comb begin
        fsm_n     = fsm_q;
        cnt_n     = cnt_q;
        complete  = 1'b0;
        ext_n     = 1'b0;
        dir_bit_n = 1'b0;
        carry_n   = 1'b0;

        if (accept) begin
            fsm_n = SEQ_COST;
            cnt_n = CNT_ONE;
        end else if (fsm_q != SEQ_IDLE) begin
            if (cnt_q == LAST) begin
                fsm_n    = SEQ_IDLE;
                complete = 1'b1;
            end else begin
                cnt_n = cnt_q + CNT_ONE;
                if (cnt_n <= COST_END) begin
                    fsm_n = SEQ_COST;
                end else if (cnt_n <= ROOT_END) begin
                    fsm_n = SEQ_ROOT;
                end else begin
                    fsm_n = SEQ_SAVE;
                end
            end
        end

        case (fsm_n)
            SEQ_COST: begin
                ext_n   = cost_next;
                carry_n = (cnt_n == COST_END);
            end
            SEQ_ROOT: begin
                ext_n     = root_next;
                dir_bit_n = (cnt_n <= DIR_END) ? dir_next : 1'b0;
            end
            SEQ_SAVE: begin
                dir_bit_n = dir_next;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q             <= SEQ_IDLE;
            cnt_q             <= '0;
            cap_q             <= '0;
            idp_state         <= STOP_ST;
            idp_pathfunction  <= 1'b0;
            idp_direction     <= 1'b0;
            idp_extern_data   <= 1'b0;
            idp_root_carry_in <= 1'b0;
            out_valid         <= 1'b0;
            out_word          <= '0;
            out_conquest      <= 1'b0;
        end else begin
            fsm_q             <= fsm_n;
            cnt_q             <= cnt_n;
            idp_state         <= to_idp_state(fsm_n);
            idp_direction     <= dir_bit_n;
            idp_extern_data   <= ext_n;
            idp_root_carry_in <= carry_n;

            if (accept) begin
                idp_pathfunction <= in_pathfunction;
            end

            // Capture holds the older TOTAL_W-1 bits; the final bit goes
            // straight into out_word so the word is ready on completion.
            if (fsm_q != SEQ_IDLE) begin
                cap_q <= {idp_result_data, cap_q[TOTAL_W-2:1]};
            end

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (complete) begin
                out_valid    <= 1'b1;
                out_word     <= {idp_result_data, cap_q};
                out_conquest <= idp_conquest;
            end
        end
    end

endmodule

// File: tb/tb_idp_sequencer.sv
// tb_idp_sequencer
//   Self-checking bench for idp_sequencer. A reference model derives, for
//   each job, the expected serial streams as plain bit vectors built from
//   the job fields, and the expected output word from the stub result bits.
module tb_idp_sequencer;

    localparam int unsigned CW = 8;
    localparam int unsigned RW = 16;
    localparam int unsigned DW = 4;
    localparam int unsigned TW = CW + RW + DW;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_cost;
    logic [RW-1:0] in_root;
    logic [DW-1:0] in_dir;
    logic          in_pathfunction;
    logic [1:0]    idp_state;
    logic          idp_pathfunction;
    logic          idp_direction;
    logic          idp_extern_data;
    logic          idp_root_carry_in;
    logic          idp_result_data;
    logic          idp_conquest;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] out_word;
    logic          out_conquest;
    logic          busy;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [TW-1:0] exp_word = '0;
    logic          exp_conq = 1'b0;

    idp_sequencer #(
        .COST_W (CW),
        .ROOT_W (RW),
        .DIR_W  (DW)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_cost           (in_cost),
        .in_root           (in_root),
        .in_dir            (in_dir),
        .in_pathfunction   (in_pathfunction),
        .idp_state         (idp_state),
        .idp_pathfunction  (idp_pathfunction),
        .idp_direction     (idp_direction),
        .idp_extern_data   (idp_extern_data),
        .idp_root_carry_in (idp_root_carry_in),
        .idp_result_data   (idp_result_data),
        .idp_conquest      (idp_conquest),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_word          (out_word),
        .out_conquest      (out_conquest),
        .busy              (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_state(input string where);
        chk({where, "_state"},     32'(idp_state),         32'd0);
        chk({where, "_in_ready"},  32'(in_ready),          32'd1);
        chk({where, "_out_valid"}, 32'(out_valid),         32'd0);
        chk({where, "_out_conq"},  32'(out_conquest),      32'd0);
        chk({where, "_out_word"},  32'(out_word),          32'd0);
        chk({where, "_busy"},      32'(busy),              32'd0);
        chk({where, "_dir"},       32'(idp_direction),     32'd0);
        chk({where, "_ext"},       32'(idp_extern_data),   32'd0);
        chk({where, "_carry"},     32'(idp_root_carry_in), 32'd0);
        chk({where, "_pf"},        32'(idp_pathfunction),  32'd0);
    endtask

    // Runs one job starting in the current cycle (the accept cycle).
    // abort_at != 0 pulses reset during that active cycle instead of
    // completing. On return from a completed job the bench is in the cycle
    // where out_valid first shows, with in_valid and out_ready low.
    task automatic run_job(input logic [CW-1:0] cost, input logic [RW-1:0] root,
                           input logic [DW-1:0] dir, input logic pf,
                           input logic [TW-1:0] res, input logic conq,
                           input int abort_at);
        logic [TW-1:0] ext_v;
        logic [TW-1:0] dir_v;
        logic [1:0]    es;

        // Bit k of each vector is the wire value during active cycle k+1.
        ext_v = {{DW{1'b0}}, root, cost};
        dir_v = {dir, {(RW-DW){1'b0}}, dir, {CW{1'b0}}};

        in_valid        = 1'b1;
        in_cost         = cost;
        in_root         = root;
        in_dir          = dir;
        in_pathfunction = pf;
        out_ready       = 1'b1;
        #1;
        chk("accept_in_ready", 32'(in_ready), 32'd1);
        chk("accept_state",    32'(idp_state), 32'd0);

        for (int c = 1; c <= int'(TW); c++) begin
            @(posedge clock);
            #1;
            // Garbage offered while busy must be ignored.
            in_valid        = 1'($urandom_range(0, 1));
            in_cost         = CW'($urandom);
            in_root         = RW'($urandom);
            in_dir          = DW'($urandom);
            in_pathfunction = 1'($urandom_range(0, 1));
            out_ready       = 1'($urandom_range(0, 1));

            es = (c <= int'(CW)) ? 2'd1 : (c <= int'(CW + RW)) ? 2'd2 : 2'd3;
            chk("run_state",     32'(idp_state),         32'(es));
            chk("run_ext",       32'(idp_extern_data),   32'(ext_v[c-1]));
            chk("run_dir",       32'(idp_direction),     32'(dir_v[c-1]));
            chk("run_carry",     32'(idp_root_carry_in), 32'(c == int'(CW)));
            chk("run_pf",        32'(idp_pathfunction),  32'(pf));
            chk("run_busy",      32'(busy),              32'd1);
            chk("run_in_ready",  32'(in_ready),          32'd0);
            chk("run_out_valid", 32'(out_valid),         32'd0);

            if (c == abort_at) begin
                in_valid = 1'b0;
                reset    = 1'b1;
                #1;
                check_reset_state("abort");
                reset = 1'b0;
                idp_result_data = 1'b0;
                idp_conquest    = 1'b0;
                return;
            end

            idp_result_data = res[c-1];
            // Conquest is only meaningful on the last SAVE cycle; drive the
            // opposite value elsewhere so a wrong sampling point shows up.
            idp_conquest = (c == int'(TW)) ? conq : ~conq;
        end

        @(posedge clock);
        #1;
        in_valid        = 1'b0;
        out_ready       = 1'b0;
        idp_result_data = 1'b0;
        idp_conquest    = 1'b0;
        exp_word        = res;
        exp_conq        = conq;
        chk("done_out_valid", 32'(out_valid),         32'd1);
        chk("done_out_word",  32'(out_word),          32'(exp_word));
        chk("done_out_conq",  32'(out_conquest),      32'(exp_conq));
        chk("done_state",     32'(idp_state),         32'd0);
        chk("done_busy",      32'(busy),              32'd0);
        chk("done_ext",       32'(idp_extern_data),   32'd0);
        chk("done_dir",       32'(idp_direction),     32'd0);
        chk("done_carry",     32'(idp_root_carry_in), 32'd0);
        chk("done_pf",        32'(idp_pathfunction),  32'(pf));
    endtask

    // Holds the result for n cycles with out_ready low, then raises out_ready.
    task automatic stall(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            chk("hold_out_valid", 32'(out_valid),    32'd1);
            chk("hold_out_word",  32'(out_word),     32'(exp_word));
            chk("hold_out_conq",  32'(out_conquest), 32'(exp_conq));
            chk("hold_in_ready",  32'(in_ready),     32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [TW-1:0] res;

        reset           = 1'b1;
        in_valid        = 1'b0;
        in_cost         = '0;
        in_root         = '0;
        in_dir          = '0;
        in_pathfunction = 1'b0;
        idp_result_data = 1'b0;
        idp_conquest    = 1'b0;
        out_ready       = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        check_reset_state("reset");
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_reset_state("idle");

        // Directed job; stub result = parity of the active cycle index.
        for (int c = 1; c <= int'(TW); c++) res[c-1] = 1'(c % 2);
        run_job(8'hA5, 16'h1234, 4'h9, 1'b0, res, 1'b1, 0);
        stall(10);

        // Accepted in the release cycle, then back-to-back with out_ready high.
        run_job(8'h3C, 16'hBEEF, 4'h6, 1'b1, TW'($urandom), 1'b0, 0);
        run_job(8'hFF, 16'h0001, 4'hF, 1'b0, TW'($urandom), 1'b1, 0);

        // Reset during ROOT: nothing may be produced afterwards.
        run_job(8'h5A, 16'h8421, 4'h3, 1'b1, TW'($urandom), 1'b1, 12);
        for (int i = 0; i < 35; i++) begin
            @(posedge clock);
            #1;
            chk("post_abort_out_valid", 32'(out_valid), 32'd0);
            chk("post_abort_state",     32'(idp_state), 32'd0);
        end

        // Randomized jobs with random result hold times.
        for (int j = 0; j < 15; j++) begin
            run_job(CW'($urandom), RW'($urandom), DW'($urandom),
                    1'($urandom_range(0, 1)), TW'($urandom),
                    1'($urandom_range(0, 1)), 0);
            stall(int'($urandom_range(0, 3)));
        end

        // Consume the final word.
        @(posedge clock);
        #1;
        chk("final_out_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
